// File: rtl/axi_lite_clint_if.sv
// AXI-lite request/response bundle between the MMIO hub and the timer/soft-IRQ block.
// The master modport is the hub side and the slave modport is the CLINT side.
interface axi_lite_clint_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    // write address / data / response
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awport;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    // read address / data
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arport;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awport, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arport, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awport, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arport, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_clint.sv
// Machine timer / software interrupt block behind an AXI-lite slave port.
// Holds mtime, mtimecmp and msip; drives the core's mtip/msip lines.
module axi_lite_clint #(
    parameter int          AXI_ADDR_WIDTH = 64,
    parameter int          AXI_DATA_WIDTH = 64,
    parameter logic [63:0] BASE_ADDR      = 64'h10000,
    parameter int          PRESCALE       = 1
) (
    input  logic            clk,
    input  logic            rst,
    axi_lite_clint_if.slave slv,
    output logic            mtip,
    output logic            msip
);
    localparam int          NUM_LANES    = AXI_DATA_WIDTH / 8;
    localparam logic [13:0] BASE_OFF     = BASE_ADDR[13:0];
    localparam logic [13:0] OFF_MSIP     = 14'h0000;
    localparam logic [13:0] OFF_MTIMECMP = 14'h0008;
    localparam logic [13:0] OFF_MTIME    = 14'h0010;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [1:0]  RESP_SLVERR  = 2'b10;
    localparam int          PRE_W        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state_reg, w_state_next;
    r_state_t r_state_reg, r_state_next;

    logic [63:0]      mtime_reg;
    logic [63:0]      mtimecmp_reg;
    logic             msip_reg;
    logic             mtip_reg;
    logic [PRE_W-1:0] pre_cnt_reg;
    logic [1:0]       bresp_reg;
    logic [63:0]      rdata_reg;
    logic [1:0]       rresp_reg;

    logic             w_hs;
    logic             r_hs;
    logic [13:0]      aw_off;
    logic [13:0]      ar_off;
    logic             aw_mapped;
    logic             sel_msip;
    logic             sel_mtimecmp;
    logic             sel_mtime;
    logic             tick;
    logic [63:0]      mtimecmp_merged;
    logic [63:0]      mtime_merged;
    logic [63:0]      rd_value;
    logic             rd_mapped;

    // Only the low 14 bits take part in decode, so the subtraction is done on them alone.
    assign aw_off = slv.awaddr[13:0] - BASE_OFF;
    assign ar_off = slv.araddr[13:0] - BASE_OFF;

    assign sel_msip     = (aw_off == OFF_MSIP);
    assign sel_mtimecmp = (aw_off == OFF_MTIMECMP);
    assign sel_mtime    = (aw_off == OFF_MTIME);
    assign aw_mapped    = sel_msip | sel_mtimecmp | sel_mtime;

    // ---------------- write channel FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_reg <= W_IDLE;
        end else begin
            w_state_reg <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = w_state_reg;
        slv.awready  = 1'b0;
        slv.wready   = 1'b0;
        slv.bvalid   = 1'b0;
        w_hs         = 1'b0;
        case (w_state_reg)
            W_IDLE: begin
                slv.awready = 1'b1;
                slv.wready  = 1'b1;
                // Address and data must arrive together; a lone half just waits.
                if (slv.awvalid && slv.wvalid) begin
                    w_hs         = 1'b1;
                    w_state_next = W_RESP;
                end
            end
            W_RESP: begin
                slv.bvalid = 1'b1;
                if (slv.bready) begin
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bresp_reg <= RESP_OKAY;
        end else if (w_hs) begin
            bresp_reg <= aw_mapped ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign slv.bresp = bresp_reg;

    // ---------------- read channel FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_reg <= R_IDLE;
        end else begin
            r_state_reg <= r_state_next;
        end
    end

    always_comb begin
        r_state_next = r_state_reg;
        slv.arready  = 1'b0;
        slv.rvalid   = 1'b0;
        r_hs         = 1'b0;
        case (r_state_reg)
            R_IDLE: begin
                slv.arready = 1'b1;
                if (slv.arvalid) begin
                    r_hs         = 1'b1;
                    r_state_next = R_DATA;
                end
            end
            R_DATA: begin
                slv.rvalid = 1'b1;
                if (slv.rready) begin
                    r_state_next = R_IDLE;
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        rd_value  = '0;
        rd_mapped = 1'b1;
        case (ar_off)
            OFF_MSIP:     rd_value = {63'd0, msip_reg};
            OFF_MTIMECMP: rd_value = mtimecmp_reg;
            OFF_MTIME:    rd_value = mtime_reg;
            default:      rd_mapped = 1'b0;
        endcase
    end

    // Captured from pre-edge register values, so a same-cycle write is not visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg <= '0;
            rresp_reg <= RESP_OKAY;
        end else if (r_hs) begin
            rdata_reg <= rd_value;
            rresp_reg <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign slv.rdata = rdata_reg;
    assign slv.rresp = rresp_reg;

    // ---------------- byte-lane merge ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign mtimecmp_merged[8*gi +: 8] = slv.wstrb[gi] ? slv.wdata[8*gi +: 8]
                                                              : mtimecmp_reg[8*gi +: 8];
            assign mtime_merged[8*gi +: 8]    = slv.wstrb[gi] ? slv.wdata[8*gi +: 8]
                                                              : mtime_reg[8*gi +: 8];
        end
    endgenerate

    // ---------------- timer state ----------------
    assign tick = (pre_cnt_reg == PRE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_reg <= '0;
        end else if (tick) begin
            pre_cnt_reg <= '0;
        end else begin
            pre_cnt_reg <= pre_cnt_reg + 1'b1;
        end
    end

    // A strobed MTIME write overrides the increment; wstrb=0 leaves the tick alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_reg <= '0;
        end else if (w_hs && sel_mtime && (|slv.wstrb)) begin
            mtime_reg <= mtime_merged;
        end else if (tick) begin
            mtime_reg <= mtime_reg + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtimecmp_reg <= '1;
        end else if (w_hs && sel_mtimecmp) begin
            mtimecmp_reg <= mtimecmp_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            msip_reg <= 1'b0;
        end else if (w_hs && sel_msip && slv.wstrb[0]) begin
            msip_reg <= slv.wdata[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtip_reg <= 1'b0;
        end else begin
            mtip_reg <= (mtime_reg >= mtimecmp_reg);
        end
    end

    assign mtip = mtip_reg;
    assign msip = msip_reg;

endmodule

// File: tb/tb_axi_lite_clint.sv
// Self-checking bench for axi_lite_clint: table vectors, timer corner sequences and
// randomized traffic against a cycle-count based reference model.
module tb_axi_lite_clint;
    localparam logic [63:0] BASE = 64'h10000;
    localparam logic [1:0]  OKAY = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mtip;
    logic msip;

    axi_lite_clint_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

    axi_lite_clint #(
        .AXI_ADDR_WIDTH(64),
        .AXI_DATA_WIDTH(64),
        .BASE_ADDR(BASE),
        .PRESCALE(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .slv(bus.slave),
        .mtip(mtip),
        .msip(msip)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    // mtime is a linear function of the edge count since the last load.
    logic [63:0] m_base;
    int          m_base_edge;
    logic [63:0] m_cmp;
    logic        m_msip;
    int          m_last_wr;

    function automatic logic [63:0] m_mtime(int e);
        return m_base + 64'(e - m_base_edge);
    endfunction

    function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] nw, logic [7:0] strb);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    function automatic logic [1:0] m_write(logic [13:0] off, logic [63:0] data, logic [7:0] strb, int e);
        case (off)
            14'h0000: begin
                if (strb[0]) m_msip = data[0];
                return OKAY;
            end
            14'h0008: begin
                m_cmp = merge(m_cmp, data, strb);
                m_last_wr = e;
                return OKAY;
            end
            14'h0010: begin
                if (strb != 8'h00) begin
                    m_base = merge(m_mtime(e - 1), data, strb);
                    m_base_edge = e;
                    m_last_wr = e;
                end
                return OKAY;
            end
            default: return SLVERR;
        endcase
    endfunction

    function automatic logic [65:0] m_read(logic [13:0] off, int e);
        case (off)
            14'h0000: return {OKAY, 63'd0, m_msip};
            14'h0008: return {OKAY, m_cmp};
            14'h0010: return {OKAY, m_mtime(e - 1)};
            default:  return {SLVERR, 64'd0};
        endcase
    endfunction

    function automatic void m_reset(int e);
        m_base = '0;
        m_base_edge = e;
        m_cmp = '1;
        m_msip = 1'b0;
        m_last_wr = e;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic check_irq(string name);
        int e;
        e = edge_n;
        chk({name, ".msip"}, 64'(msip), 64'(m_msip));
        if (e - 1 >= m_last_wr)
            chk({name, ".mtip"}, 64'(mtip), 64'(m_mtime(e - 1) >= m_cmp));
    endtask

    task automatic bus_idle();
        bus.awaddr = '0; bus.awport = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arport = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_idle();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        m_reset(edge_n);
    endtask

    task automatic do_write(logic [13:0] off, logic [63:0] data, logic [7:0] strb, int bdelay,
                            output logic [1:0] resp);
        logic [1:0] exp;
        int n;
        n = 0;
        while (bus.awready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) chk("aw_wait_timeout", 64'(bus.awready), 64'd1);
        bus.awaddr = BASE + 64'(off);
        bus.awport = 3'($urandom_range(0, 7));
        bus.wdata = data; bus.wstrb = strb;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(posedge clk); #1;
        exp = m_write(off, data, strb, edge_n);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("wr.bvalid", 64'(bus.bvalid), 64'd1);
        chk("wr.awready_busy", 64'(bus.awready), 64'd0);
        chk("wr.bresp", 64'(bus.bresp), 64'(exp));
        resp = bus.bresp;
        for (int i = 0; i < bdelay; i++) begin
            @(posedge clk); #1;
            chk("wr.bvalid_hold", 64'(bus.bvalid), 64'd1);
            chk("wr.bresp_hold", 64'(bus.bresp), 64'(exp));
            chk("wr.ready_hold", 64'({bus.awready, bus.wready}), 64'd0);
        end
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
        chk("wr.bvalid_drop", 64'(bus.bvalid), 64'd0);
        chk("wr.awready_back", 64'(bus.awready), 64'd1);
    endtask

    task automatic do_read(logic [13:0] off, int rdelay, output logic [63:0] data, output logic [1:0] resp);
        logic [65:0] exp;
        bus.araddr = BASE + 64'(off);
        bus.arport = 3'($urandom_range(0, 7));
        bus.arvalid = 1'b1;
        @(posedge clk); #1;
        exp = m_read(off, edge_n);
        bus.arvalid = 1'b0;
        chk("rd.rvalid", 64'(bus.rvalid), 64'd1);
        chk("rd.arready_busy", 64'(bus.arready), 64'd0);
        chk("rd.rdata", bus.rdata, exp[63:0]);
        chk("rd.rresp", 64'(bus.rresp), 64'(exp[65:64]));
        data = bus.rdata;
        resp = bus.rresp;
        for (int i = 0; i < rdelay; i++) begin
            @(posedge clk); #1;
            chk("rd.rvalid_hold", 64'(bus.rvalid), 64'd1);
            chk("rd.rdata_hold", bus.rdata, exp[63:0]);
            chk("rd.rresp_hold", 64'(bus.rresp), 64'(exp[65:64]));
            chk("rd.arready_hold", 64'(bus.arready), 64'd0);
        end
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
        chk("rd.rvalid_drop", 64'(bus.rvalid), 64'd0);
        chk("rd.arready_back", 64'(bus.arready), 64'd1);
    endtask

    // Write MTIME near the top and read it back d cycles later (d=0: same edge as the write).
    task automatic wrap_seq(int d, logic [63:0] exp_val);
        logic [63:0] exp_rd;
        int w;
        bus.awaddr = BASE + 64'h10; bus.wdata = 64'hFFFF_FFFF_FFFF_FFFE; bus.wstrb = 8'hFF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        exp_rd = exp_val;
        if (d == 0) begin
            exp_rd = m_mtime(edge_n);
            bus.araddr = BASE + 64'h10; bus.arvalid = 1'b1;
        end
        @(posedge clk); #1;
        w = edge_n;
        m_write(14'h0010, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, w);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        if (d > 0) begin
            for (int i = 1; i < d; i++) begin
                @(posedge clk); #1;
                check_irq("wrap_wait");
            end
            bus.araddr = BASE + 64'h10; bus.arvalid = 1'b1;
            @(posedge clk); #1;
        end
        bus.arvalid = 1'b0;
        chk($sformatf("wrap.d%0d.rvalid", d), 64'(bus.rvalid), 64'd1);
        chk($sformatf("wrap.d%0d.rdata", d), bus.rdata, exp_rd);
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0; bus.bready = 1'b0;
        chk("wrap.bvalid_done", 64'(bus.bvalid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_irq("wrap_post");
        end
    endtask

    typedef struct {
        bit          wr;
        logic [13:0] off;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [1:0]  resp;
        logic [63:0] rdata;
    } vec_t;

    vec_t tbl[20];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [63:0] rd;
        int          first_e;
        int          t_reach;

        tbl[0]  = '{1, 14'h0000, 64'h1,                  8'h01, OKAY,   64'h0};
        tbl[1]  = '{0, 14'h0000, 64'h0,                  8'h00, OKAY,   64'h1};
        tbl[2]  = '{1, 14'h0000, 64'h0,                  8'h00, OKAY,   64'h0};
        tbl[3]  = '{0, 14'h0000, 64'h0,                  8'h00, OKAY,   64'h1};
        tbl[4]  = '{1, 14'h0000, 64'h0,                  8'h01, OKAY,   64'h0};
        tbl[5]  = '{0, 14'h0000, 64'h0,                  8'h00, OKAY,   64'h0};
        tbl[6]  = '{1, 14'h0000, 64'h1,                  8'hFE, OKAY,   64'h0};
        tbl[7]  = '{0, 14'h0000, 64'h0,                  8'h00, OKAY,   64'h0};
        tbl[8]  = '{1, 14'h0008, 64'h1122_3344_5566_7788, 8'hFF, OKAY,   64'h0};
        tbl[9]  = '{0, 14'h0008, 64'h0,                  8'h00, OKAY,   64'h1122_3344_5566_7788};
        tbl[10] = '{1, 14'h0008, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, OKAY,   64'h0};
        tbl[11] = '{0, 14'h0008, 64'h0,                  8'h00, OKAY,   64'h1122_3344_BBBB_BBBB};
        tbl[12] = '{1, 14'h0008, 64'hCC00_0000_0000_0000, 8'h80, OKAY,   64'h0};
        tbl[13] = '{0, 14'h0008, 64'h0,                  8'h00, OKAY,   64'hCC22_3344_BBBB_BBBB};
        tbl[14] = '{1, 14'h0018, 64'h1234,               8'hFF, SLVERR, 64'h0};
        tbl[15] = '{0, 14'h0018, 64'h0,                  8'h00, SLVERR, 64'h0};
        tbl[16] = '{0, 14'h0004, 64'h0,                  8'h00, SLVERR, 64'h0};
        tbl[17] = '{1, 14'h3FF8, 64'h5555,               8'hFF, SLVERR, 64'h0};
        tbl[18] = '{0, 14'h0008, 64'h0,                  8'h00, OKAY,   64'hCC22_3344_BBBB_BBBB};
        tbl[19] = '{1, 14'h0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, OKAY,   64'h0};

        // Reset state and idle count
        do_reset();
        chk("rst.bvalid", 64'(bus.bvalid), 64'd0);
        chk("rst.rvalid", 64'(bus.rvalid), 64'd0);
        chk("rst.ready", 64'({bus.awready, bus.wready, bus.arready}), 64'h7);
        chk("rst.bresp", 64'(bus.bresp), 64'd0);
        chk("rst.rresp", 64'(bus.rresp), 64'd0);
        chk("rst.rdata", bus.rdata, 64'd0);
        chk("rst.mtip", 64'(mtip), 64'd0);
        chk("rst.msip", 64'(msip), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        do_read(14'h0010, 0, rd, resp);
        chk("idle10.mtime", rd, 64'd10);
        chk("idle10.rresp", 64'(resp), 64'(OKAY));
        check_irq("idle10");

        // Compare match: mtip rises one cycle after mtime reaches mtimecmp
        do_reset();
        do_write(14'h0008, 64'h20, 8'hFF, 0, resp);
        chk("cmp.bresp", 64'(resp), 64'(OKAY));
        t_reach = m_base_edge + int'(64'h20 - m_base);
        first_e = -1;
        for (int i = 0; i < 100 && first_e < 0; i++) begin
            if (mtip === 1'b1) first_e = edge_n;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("cmp.mtip_rise_edge", 64'(first_e), 64'(t_reach + 1));
        check_irq("cmp_after");

        // Wrap around all-ones, write beats the tick
        wrap_seq(0, 64'h0);
        wrap_seq(1, 64'hFFFF_FFFF_FFFF_FFFE);
        wrap_seq(2, 64'hFFFF_FFFF_FFFF_FFFF);
        wrap_seq(3, 64'h0);

        // Table vectors
        do_reset();
        foreach (tbl[i]) begin
            if (tbl[i].wr) begin
                do_write(tbl[i].off, tbl[i].data, tbl[i].strb, int'($urandom_range(0, 2)), resp);
                chk($sformatf("tbl%0d.bresp", i), 64'(resp), 64'(tbl[i].resp));
            end else begin
                do_read(tbl[i].off, int'($urandom_range(0, 2)), rd, resp);
                chk($sformatf("tbl%0d.rresp", i), 64'(resp), 64'(tbl[i].resp));
                chk($sformatf("tbl%0d.rdata", i), rd, tbl[i].rdata);
            end
            check_irq($sformatf("tbl%0d", i));
        end

        // Backpressure on an unmapped offset, then confirm nothing moved
        do_write(14'h0000, 64'h1, 8'h01, 0, resp);
        do_write(14'h0018, 64'hDEAD_BEEF, 8'hFF, 5, resp);
        chk("bp.bresp", 64'(resp), 64'(SLVERR));
        do_read(14'h0018, 5, rd, resp);
        chk("bp.rresp", 64'(resp), 64'(SLVERR));
        chk("bp.rdata", rd, 64'd0);
        do_read(14'h0008, 0, rd, resp);
        chk("bp.cmp_kept", rd, 64'hFFFF_FFFF_FFFF_FFFF);
        do_read(14'h0000, 0, rd, resp);
        chk("bp.msip_kept", rd, 64'd1);

        // Reset while both channels hold a pending response
        bus.awaddr = BASE + 64'h8; bus.wdata = 64'h5; bus.wstrb = 8'hFF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        bus.araddr = BASE + 64'h10; bus.arvalid = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        @(posedge clk); #1;
        chk("midrst.pending", 64'({bus.bvalid, bus.rvalid}), 64'h3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset(edge_n);
        chk("midrst.valids", 64'({bus.bvalid, bus.rvalid}), 64'd0);
        chk("midrst.ready", 64'({bus.awready, bus.arready}), 64'h3);
        chk("midrst.msip", 64'(msip), 64'd0);
        do_read(14'h0010, 0, rd, resp);
        chk("midrst.mtime", rd, 64'd0);
        do_read(14'h0008, 0, rd, resp);
        chk("midrst.mtimecmp", rd, 64'hFFFF_FFFF_FFFF_FFFF);

        // Randomized traffic against the model
        for (int it = 0; it < 60; it++) begin
            logic [13:0] offs [6];
            logic [13:0] off;
            logic [63:0] data;
            logic [7:0]  strb;
            offs = '{14'h0000, 14'h0008, 14'h0010, 14'h0018, 14'h0004, 14'h3FF8};
            off  = offs[$urandom_range(0, 5)];
            strb = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) strb = 8'hFF;
            // keep values near the running time so mtip toggles both ways
            data = m_mtime(edge_n) + 64'($urandom_range(0, 40)) - 64'd20;
            if ($urandom_range(0, 3) == 0) data = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1)
                do_write(off, data, strb, int'($urandom_range(0, 3)), resp);
            else
                do_read(off, int'($urandom_range(0, 3)), rd, resp);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            check_irq($sformatf("rnd%0d", it));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
